// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV64I field bundles back into 32-bit
// instruction words and streams them into instruction memory, one word per
// accepted bundle, starting at a programmable base address. Bundles that
// cannot be encoded are consumed and dropped, and they set a sticky error flag.
module instr_encoder_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [63:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_OPIMM  = 3'd1;
  localparam logic [2:0] FMT_LOAD   = 3'd2;
  localparam logic [2:0] FMT_STORE  = 3'd3;
  localparam logic [2:0] FMT_BRANCH = 3'd4;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                hold_valid_q;
  logic                hold_last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [CNT_W-1:0]    count_q;

  logic [31:0]         wdata_d;
  logic                reject_d;
  logic                is_shift;
  logic signed [63:0]  imm_s;
  logic                accept;
  logic                drain;

  assign imm_s    = in_imm;
  assign is_shift = (in_fmt == FMT_OPIMM) &&
                    ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

  // The hold stage may take a new bundle when it is empty or is being drained
  // into memory this very cycle, which keeps writes back-to-back.
  assign in_ready = (state_q == RUN) && (!hold_valid_q || imem_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = hold_valid_q && imem_ready;

  assign imem_we    = hold_valid_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign count      = count_q;

  // Encode the incoming bundle and flag it if its immediate cannot be
  // represented in the target format or the format code is unknown.
  always_comb begin
    wdata_d  = 32'h0;
    reject_d = 1'b0;
    case (in_fmt)
      FMT_R: begin
        wdata_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      end
      FMT_OPIMM: begin
        if (is_shift) begin
          wdata_d  = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          reject_d = (imm_s < 64'sd0) || (imm_s > 64'sd63);
        end else begin
          wdata_d  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          reject_d = (imm_s < -64'sd2048) || (imm_s > 64'sd2047);
        end
      end
      FMT_LOAD: begin
        wdata_d  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        reject_d = (imm_s < -64'sd2048) || (imm_s > 64'sd2047);
      end
      FMT_STORE: begin
        wdata_d  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        reject_d = (imm_s < -64'sd2048) || (imm_s > 64'sd2047);
      end
      FMT_BRANCH: begin
        wdata_d  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
        reject_d = (imm_s < -64'sd4096) || (imm_s > 64'sd4094) || in_imm[0];
      end
      default: begin
        reject_d = 1'b1;
      end
    endcase
  end

  // Program framing FSM together with the one-deep hold stage, write address
  // and word counter; a pending write is simply dropped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      count_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q      <= RUN;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            addr_q       <= base_addr & ~ADDR_W'(3);
            count_q      <= '0;
          end
        end
        RUN: begin
          if (drain) begin
            hold_valid_q <= 1'b0;
            addr_q       <= addr_q + ADDR_W'(4);
            count_q      <= count_q + CNT_W'(1);
          end
          if (accept) begin
            if (reject_d) begin
              err_q <= 1'b1;
            end else begin
              hold_valid_q <= 1'b1;
              hold_last_q  <= in_last;
              wdata_q      <= wdata_d;
            end
          end
          if ((drain && hold_last_q) || (accept && reject_d && in_last)) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            hold_valid_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          hold_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader: inputs are driven and outputs
// sampled on the falling clock edge, expected values are hand-encoded words.
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [63:0] in_imm;
  logic        in_last;
  logic        imem_we;
  logic        imem_ready;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  count;

  int passCount;
  int checkCount;

  instr_encoder_loader #(.ADDR_W(12), .CNT_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one field bundle onto the input stream.
  task automatic applyStimulus(input logic v, input logic [2:0] fmt, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [63:0] imm, input logic last);
    in_valid  = v;
    in_fmt    = fmt;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_last   = last;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Linear directed test sequence.
  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = 12'h0;
    imem_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);

    // Reset values
    @(negedge clk);
    checkOutput("rst_we", imem_we, 0);
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_wdata", imem_wdata, 0);
    checkOutput("rst_count", count, 0);
    rst_n = 1'b1;

    // Single ADD at base 0x100
    start = 1'b1; base_addr = 12'h100;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_ready", in_ready, 1);
    checkOutput("t1_base", imem_addr, 12'h100);
    checkOutput("t1_cnt0", count, 0);
    applyStimulus(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    checkOutput("t1_we", imem_we, 1);
    checkOutput("t1_addr", imem_addr, 12'h100);
    checkOutput("t1_add", imem_wdata, 32'h002081B3);
    @(negedge clk);
    checkOutput("t1_cnt1", count, 1);
    checkOutput("t1_we_off", imem_we, 0);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_addr_inc", imem_addr, 12'h104);
    @(negedge clk);
    checkOutput("t1_done_off", done, 0);
    checkOutput("t1_busy_off", busy, 0);
    // A valid bundle in IDLE must not be taken
    applyStimulus(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1'b0);
    #1;
    checkOutput("idle_ready", in_ready, 0);
    @(negedge clk);
    checkOutput("idle_we", imem_we, 0);
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);

    // Back-to-back ADDI then SD
    start = 1'b1; base_addr = 12'h100;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd3, 7'd0, 64'd8, 1'b1);
    checkOutput("t2_we0", imem_we, 1);
    checkOutput("t2_addr0", imem_addr, 12'h100);
    checkOutput("t2_addi", imem_wdata, 32'hFFF00293);
    checkOutput("t2_ready", in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    checkOutput("t2_we1", imem_we, 1);
    checkOutput("t2_addr1", imem_addr, 12'h104);
    checkOutput("t2_sd", imem_wdata, 32'h0020B423);
    checkOutput("t2_cnt1", count, 1);
    @(negedge clk);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_busy", busy, 0);
    checkOutput("t2_we_off", imem_we, 0);
    checkOutput("t2_cnt2", count, 2);
    @(negedge clk);
    checkOutput("t2_done_off", done, 0);

    // BEQ and SRAI encodings
    start = 1'b1; base_addr = 12'h200;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd8, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 3'd1, 5'd4, 5'd4, 5'd0, 3'd5, 7'h20, 64'd3, 1'b1);
    checkOutput("t3_beq", imem_wdata, 32'hFE208CE3);
    checkOutput("t3_addr0", imem_addr, 12'h200);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    checkOutput("t3_srai", imem_wdata, 32'h40325213);
    checkOutput("t3_addr1", imem_addr, 12'h204);
    @(negedge clk);
    checkOutput("t3_done", done, 1);
    @(negedge clk);

    // Rejected bundles: odd branch offset, out-of-range ADDI
    start = 1'b1; base_addr = 12'h300;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd7, 1'b0);
    checkOutput("t4_ready0", in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4096, 1'b0);
    checkOutput("t4_err0", err, 1);
    checkOutput("t4_we0", imem_we, 0);
    checkOutput("t4_addr0", imem_addr, 12'h300);
    checkOutput("t4_ready1", in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1'b1);
    checkOutput("t4_err1", err, 1);
    checkOutput("t4_we1", imem_we, 0);
    checkOutput("t4_addr1", imem_addr, 12'h300);
    checkOutput("t4_cnt", count, 0);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    checkOutput("t4_we2", imem_we, 1);
    checkOutput("t4_wdata", imem_wdata, 32'h002081B3);
    checkOutput("t4_addr2", imem_addr, 12'h300);
    @(negedge clk);
    checkOutput("t4_done", done, 1);
    checkOutput("t4_cnt1", count, 1);
    checkOutput("t4_err_sticky", err, 1);
    @(negedge clk);

    // Backpressure: memory stalls for three cycles
    start = 1'b1; base_addr = 12'h400;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5_err_clr", err, 0);
    imem_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t5_stall_ready", in_ready, 0);
      checkOutput("t5_stall_we", imem_we, 1);
      checkOutput("t5_stall_addr", imem_addr, 12'h400);
      checkOutput("t5_stall_wdata", imem_wdata, 32'h002081B3);
    end
    imem_ready = 1'b1;
    #1;
    checkOutput("t5_ready_back", in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    checkOutput("t5_wdata2", imem_wdata, 32'hFFF00293);
    checkOutput("t5_addr2", imem_addr, 12'h404);
    checkOutput("t5_cnt1", count, 1);
    @(negedge clk);
    checkOutput("t5_done", done, 1);
    checkOutput("t5_cnt2", count, 2);
    @(negedge clk);

    // Address wrap from 0xFFC, then asynchronous reset mid-stream
    start = 1'b1; base_addr = 12'hFFF;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t6_base_align", imem_addr, 12'hFFC);
    applyStimulus(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1, 1'b0);
    checkOutput("t6_we0", imem_we, 1);
    checkOutput("t6_addr0", imem_addr, 12'hFFC);
    @(negedge clk);
    applyStimulus(1'b1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd3, 7'd0, 64'd8, 1'b0);
    checkOutput("t6_addr_wrap", imem_addr, 12'h000);
    checkOutput("t6_cnt1", count, 1);
    checkOutput("t6_we1", imem_we, 1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    checkOutput("t6_addr2", imem_addr, 12'h004);
    checkOutput("t6_cnt2", count, 2);
    checkOutput("t6_wdata2", imem_wdata, 32'h0020B423);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_we", imem_we, 0);
    checkOutput("t6_rst_ready", in_ready, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_addr", imem_addr, 0);
    checkOutput("t6_rst_wdata", imem_wdata, 0);
    checkOutput("t6_rst_count", count, 0);
    checkOutput("t6_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_post_we", imem_we, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the instruction decoder. Accepts decoded instruction fields (format, registers, funct3/funct7, signed 64-bit immediate) over a valid/ready stream, packs them into 32-bit RV64I words, and writes them sequentially into instruction memory from a programmable base address. It is used by the testbench/boot path to load programs that the sequential core then fetches and decodes.
- One-deep output stage with backpressure.
- Immediate range and alignment checking.
- Program-level start/last/done framing.

Parameters:
ADDR_W, 12, byte-address width of the instruction-memory write port.
CNT_W, 10, width of the written-word counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; loads base_addr, clears count and err, enters RUN. Ignored unless IDLE.
base_addr  input  ADDR_W  first byte address; bits [1:0] are forced to 0.
in_valid  input  1  field bundle valid.
in_ready  output  1  bundle accepted when in_valid and in_ready.
in_fmt  input  3  0=R, 1=OP-IMM, 2=LOAD, 3=STORE, 4=BRANCH; 5-7 invalid.
in_rd, in_rs1, in_rs2  input  5 each  register fields.
in_funct3  input  3  funct3.
in_funct7  input  7  funct7 (R type; OP-IMM shifts use bits [6:1]).
in_imm  input  64  signed immediate.
in_last  input  1  marks the final bundle of the program.
imem_we  output  1  write request.
imem_ready  input  1  memory accepts the write this cycle.
imem_addr  output  ADDR_W  byte address of the write.
imem_wdata  output  32  encoded instruction word.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when the last word has been written.
err  output  1  sticky; set on any rejected bundle.
count  output  CNT_W  words written since start.

Behaviour:
- Reset: FSM=IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, count = 0; hold register empty.
- FSM states:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: busy=1. Leaves to DONE when the held word with last=1 completes a write (imem_we && imem_ready), or when a last bundle is rejected.
  - DONE: done=1 for one cycle, then IDLE.
- Handshake:
  - In RUN, in_ready = !hold_valid || imem_ready.
  - An accepted valid bundle is encoded and registered into the hold stage next cycle (latency 1 cycle to imem_we).
  - imem_we = hold_valid. imem_addr and imem_wdata are stable while imem_ready=0.
  - On imem_we && imem_ready: imem_addr += 4 (wraps modulo 2^ADDR_W), count += 1 (wraps).
  - Simultaneous drain and accept in the same cycle gives back-to-back writes with no bubble.
- Encoding:
  - R: {f7, rs2, rs1, f3, rd, 0110011}.
  - OP-IMM with f3=001/101: {f7[6:1], imm[5:0], rs1, f3, rd, 0010011}.
  - Other OP-IMM: {imm[11:0], rs1, f3, rd, 0010011}.
  - LOAD: {imm[11:0], rs1, f3, rd, 0000011}.
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
  - Fields are encoded as given; there is no rs1/rs2 swap for any branch type.
- Rejection (bundle is still consumed; no write; err set; address and count unchanged):
  - in_fmt > 4.
  - I/LOAD/STORE imm outside [-2048, 2047].
  - Shift imm outside [0, 63].
  - Branch imm outside [-4096, 4094], or imm[0]=1.
- Reset mid-operation aborts immediately and discards the hold word; a pending write is not completed.
- start during RUN or DONE is ignored.
- in_valid in IDLE is not accepted.

Test Plan:
- start base=0x100; ADD rd=3 rs1=1 rs2=2 f3=0 f7=0 -> imem_we with addr 0x100, wdata 0x002081B3; count=1.
- Back-to-back: ADDI rd=5 rs1=0 imm=-1, then SD rs1=1 rs2=2 f3=3 imm=8 (last) -> 0xFFF00293 @0x100, then 0x0020B423 @0x104 on consecutive cycles; done pulse one cycle later; busy falls.
- BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3. SRAI rd=4 rs1=4 f3=5 f7=0x20 imm=3 -> 0x40325213.
- BRANCH imm=7, then ADDI imm=4096 -> both consumed, no writes, err=1, addr/count unchanged; a following valid bundle writes normally; next start clears err.
- imem_ready held low 3 cycles with in_valid high -> in_ready=0, addr/wdata stable, no bundle lost; writes resume in order once ready rises.
- base=0xFFC with ADDR_W=12, two words -> addresses 0xFFC then 0x000. Assert rst_n mid-stream -> all outputs at reset values asynchronously.
